// File: rtl/fsm_convert_fixed_to_float.sv
// Control sequencer for the fixed-to-float converter.
// It steps the register enables, the shifter load and the shift select through a fixed 6-cycle schedule, then holds ACK_FF.
module fsm_convert_fixed_to_float #(
    parameter logic [7:0] EXP_REF = 8'd26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Begin_FSM,
    input  logic [7:0] Encd,
    input  logic       Bandcomp,
    output logic       EN_REG1,
    output logic       EN_REGmult,
    output logic       LOAD,
    output logic       MS_1,
    output logic       EN_REG2,
    output logic       ACK_FF,
    output logic       Busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FIXED,
        LOAD_MULT,
        COMPARE,
        SHIFT,
        SETTLE,
        STORE,
        DONE
    } state_t;

    state_t r_state;
    logic   r_msFlag;
    logic   Band_q;

    // Each output register is loaded with the value for the state being entered.
    // As a result, every output is a clean flop that lines up with r_state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_msFlag   <= 1'b0;
            Band_q     <= 1'b0;
            EN_REG1    <= 1'b0;
            EN_REGmult <= 1'b0;
            LOAD       <= 1'b0;
            MS_1       <= 1'b0;
            EN_REG2    <= 1'b0;
            ACK_FF     <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            EN_REG1    <= 1'b0;
            EN_REGmult <= 1'b0;
            LOAD       <= 1'b0;
            MS_1       <= 1'b0;
            EN_REG2    <= 1'b0;
            ACK_FF     <= 1'b0;
            Busy       <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (Begin_FSM) begin
                        r_state <= LOAD_FIXED;
                        EN_REG1 <= 1'b1;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                LOAD_FIXED: begin
                    r_state    <= LOAD_MULT;
                    EN_REGmult <= 1'b1;
                end
                LOAD_MULT: begin
                    r_state <= COMPARE;
                end
                // The flag is captured here, and MS_1 gets the same value, so SHIFT already drives it.
                COMPARE: begin
                    r_state  <= SHIFT;
                    r_msFlag <= (Encd != EXP_REF);
                    MS_1     <= (Encd != EXP_REF);
                    LOAD     <= 1'b1;
                end
                SHIFT: begin
                    r_state <= SETTLE;
                    Band_q  <= Bandcomp;
                    MS_1    <= r_msFlag;
                end
                SETTLE: begin
                    r_state <= STORE;
                    MS_1    <= r_msFlag;
                    EN_REG2 <= 1'b1;
                end
                STORE: begin
                    r_state <= DONE;
                    ACK_FF  <= 1'b1;
                end
                DONE: begin
                    if (Begin_FSM) begin
                        ACK_FF <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        Busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_convert_fixed_to_float.sv
// Directed self-checking bench for fsm_convert_fixed_to_float.
// Outputs are packed as {EN_REG1,EN_REGmult,LOAD,MS_1,EN_REG2,ACK_FF,Busy}.
module tb_fsm_convert_fixed_to_float;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Begin_FSM = 1'b0;
    logic [7:0] Encd = 8'd0;
    logic       Bandcomp = 1'b0;
    logic       EN_REG1, EN_REGmult, LOAD, MS_1, EN_REG2, ACK_FF, Busy;

    int errCount = 0;
    int checkCount = 0;
    int cycleCount = 0;
    int startA, startB;

    fsm_convert_fixed_to_float #(.EXP_REF(8'd26)) dut (
        .CLK(CLK), .RST(RST), .Begin_FSM(Begin_FSM), .Encd(Encd), .Bandcomp(Bandcomp),
        .EN_REG1(EN_REG1), .EN_REGmult(EN_REGmult), .LOAD(LOAD), .MS_1(MS_1),
        .EN_REG2(EN_REG2), .ACK_FF(ACK_FF), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCount <= cycleCount + 1;

    function automatic logic [6:0] outVec();
        return {EN_REG1, EN_REGmult, LOAD, MS_1, EN_REG2, ACK_FF, Busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Mode 0: a single-cycle Begin pulse. Mode 1: Begin held high. Mode 2: Begin toggled while busy.
    task automatic applyStimulus(input logic [7:0] encd, input logic band, input int mode, output int startCycle);
        logic [6:0] expTbl [7];
        logic [6:0] ms;
        ms = (encd != 8'd26) ? 7'b0001000 : 7'b0000000;
        expTbl[0] = 7'b1000001;
        expTbl[1] = 7'b0100001;
        expTbl[2] = 7'b0000001;
        expTbl[3] = 7'b0010001 | ms;
        expTbl[4] = 7'b0000001 | ms;
        expTbl[5] = 7'b0000101 | ms;
        expTbl[6] = 7'b0000011;
        Begin_FSM = 1'b1;
        Encd = encd;
        Bandcomp = band;
        tick();
        startCycle = cycleCount;
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("seq%0d_e%0d_m%0d", i, encd, mode), {25'd0, outVec()}, {25'd0, expTbl[i]});
            if (mode == 1) Begin_FSM = 1'b1;
            else if (mode == 2) Begin_FSM = (i % 2 == 1);
            else Begin_FSM = 1'b0;
            if (i < 6) tick();
        end
        checkOutput($sformatf("bandq_e%0d", encd), {31'd0, dut.Band_q}, {31'd0, band});
        if (mode == 1) begin
            for (int j = 0; j < 13; j++) begin
                tick();
                checkOutput("hold_done", {25'd0, outVec()}, 32'h03);
            end
            Begin_FSM = 1'b0;
        end
        tick();
        checkOutput("back_idle", {25'd0, outVec()}, 32'h00);
    endtask

    initial begin
        int s;
        RST = 1'b1;
        tick();
        checkOutput("reset", {25'd0, outVec()}, 32'h00);
        RST = 1'b0;
        tick();
        checkOutput("idle", {25'd0, outVec()}, 32'h00);

        applyStimulus(8'd30, 1'b1, 0, s);
        applyStimulus(8'd26, 1'b0, 0, s);
        applyStimulus(8'd20, 1'b0, 0, s);

        applyStimulus(8'd28, 1'b1, 1, s);
        tick();
        checkOutput("no_restart", {25'd0, outVec()}, 32'h00);

        applyStimulus(8'd22, 1'b0, 2, s);

        // Reset while the sequencer is in SHIFT.
        Begin_FSM = 1'b1;
        Encd = 8'd31;
        tick();
        Begin_FSM = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("in_shift", {25'd0, outVec()}, 32'h19);
        RST = 1'b1;
        tick();
        checkOutput("mid_reset", {25'd0, outVec()}, 32'h00);
        RST = 1'b0;
        applyStimulus(8'd31, 1'b1, 0, s);

        // Reset takes priority over a start request.
        RST = 1'b1;
        Begin_FSM = 1'b1;
        tick();
        checkOutput("rst_begin_1", {25'd0, outVec()}, 32'h00);
        tick();
        checkOutput("rst_begin_2", {25'd0, outVec()}, 32'h00);
        RST = 1'b0;
        Begin_FSM = 1'b0;
        tick();

        applyStimulus(8'd30, 1'b0, 0, startA);
        applyStimulus(8'd26, 1'b0, 0, startB);
        checkOutput("b2b_period", startB - startA, 32'd8);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
